// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipelined Beta-style processor.
// Evaluates the ALU function on the ID/EX bundle and registers the EX/MEM bundle.
// Single-cycle ops complete in one cycle. MUL is a MUL_CYCLES-iteration shift-add.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid / ex_ready   ID/EX handshake (ex_ready is combinational)
//   EX_PC, EX_ALUFN       instruction PC, ALU function code
//   EX_A, EX_B            ALU operands
//   EX_D, EX_ID           store data and instruction tag, passed through
//   ex_flush              synchronous squash of everything in flight
//   mem_valid / mem_ready EX/MEM handshake
//   MEM_PC, MEM_Y         registered PC and ALU result
//   MEM_D, MEM_ID         registered store data and tag
//   busy                  multiplier in progress
module ex_stage #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic [WIDTH-1:0] EX_PC,
   input  logic [5:0]       EX_ALUFN,
   input  logic [WIDTH-1:0] EX_A,
   input  logic [WIDTH-1:0] EX_B,
   input  logic [WIDTH-1:0] EX_D,
   input  logic [WIDTH-1:0] EX_ID,
   input  logic             ex_flush,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] MEM_PC,
   output logic [WIDTH-1:0] MEM_Y,
   output logic [WIDTH-1:0] MEM_D,
   output logic [WIDTH-1:0] MEM_ID,
   output logic             busy
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
   localparam logic [5:0] FN_MUL = 6'b000010;
   localparam logic [5:0] FN_EQ  = 6'b110011;
   localparam logic [5:0] FN_LT  = 6'b110101;
   localparam logic [5:0] FN_LE  = 6'b110111;

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t state_q, state_d;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mpa_q, mpa_d;
   logic [WIDTH-1:0] mpb_q, mpb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mpc_q, mpc_d;
   logic [WIDTH-1:0] md_q, md_d;
   logic [WIDTH-1:0] mid_q, mid_d;

   logic             mem_valid_q, mem_valid_d;
   logic [WIDTH-1:0] mem_pc_q, mem_pc_d;
   logic [WIDTH-1:0] mem_y_q, mem_y_d;
   logic [WIDTH-1:0] mem_d_q, mem_d_d;
   logic [WIDTH-1:0] mem_id_q, mem_id_d;

   logic             out_free;
   logic             is_mul;
   logic             load_alu;
   logic             load_mul;
   logic             mul_start;
   logic             mul_step;
   logic [WIDTH-1:0] alu_y;
   logic [WIDTH-1:0] acc_step;
   logic [SHW-1:0]   shamt;
   logic [3:0]       fn_lo;

   assign out_free = !mem_valid_q || mem_ready;
   assign is_mul   = (EX_ALUFN == FN_MUL);
   assign shamt    = EX_B[SHW-1:0];
   assign fn_lo    = EX_ALUFN[3:0];

   // Single-cycle ALU; MUL is handled by the iterative datapath below.
   always_comb begin
      alu_y = '0;
      case (EX_ALUFN[5:4])
         2'b00: begin
            case (fn_lo)
               4'b0000: alu_y = EX_A + EX_B;
               4'b0001: alu_y = EX_A - EX_B;
               default: alu_y = '0;
            endcase
         end
         2'b01: begin
            // Each result bit is a lookup into the 4-bit truth table in ALUFN[3:0].
            for (int i = 0; i < int'(WIDTH); i++) begin
               alu_y[i] = fn_lo[{EX_B[i], EX_A[i]}];
            end
         end
         2'b10: begin
            case (EX_ALUFN[1:0])
               2'b00:   alu_y = EX_A << shamt;
               2'b01:   alu_y = EX_A >> shamt;
               2'b11:   alu_y = WIDTH'($signed(EX_A) >>> shamt);
               default: alu_y = EX_A;
            endcase
         end
         default: begin
            case (EX_ALUFN)
               FN_EQ:   alu_y = {{(WIDTH-1){1'b0}}, EX_A == EX_B};
               FN_LT:   alu_y = {{(WIDTH-1){1'b0}}, $signed(EX_A) < $signed(EX_B)};
               FN_LE:   alu_y = {{(WIDTH-1){1'b0}}, $signed(EX_A) <= $signed(EX_B)};
               default: alu_y = '0;
            endcase
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a flush always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (mul_start) state_d = S_MUL;
         S_MUL:   if (load_mul)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (ex_flush) state_d = S_IDLE;
   end

   // FSM outputs. The last MUL iteration stalls until the output register can take it.
   always_comb begin
      ex_ready  = 1'b0;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      case (state_q)
         S_IDLE: begin
            ex_ready  = out_free && !ex_flush;
            load_alu  = ex_valid && ex_ready && !is_mul;
            mul_start = ex_valid && ex_ready && is_mul;
         end
         S_MUL: begin
            if (!ex_flush) begin
               if (cnt_q != CNT_LAST) begin
                  mul_step = 1'b1;
               end else if (out_free) begin
                  mul_step = 1'b1;
                  load_mul = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Multiplier and output register next-state.
   always_comb begin
      acc_step    = acc_q + (mpb_q[0] ? mpa_q : '0);
      cnt_d       = cnt_q;
      mpa_d       = mpa_q;
      mpb_d       = mpb_q;
      acc_d       = acc_q;
      mpc_d       = mpc_q;
      md_d        = md_q;
      mid_d       = mid_q;
      mem_pc_d    = mem_pc_q;
      mem_y_d     = mem_y_q;
      mem_d_d     = mem_d_q;
      mem_id_d    = mem_id_q;
      mem_valid_d = mem_valid_q && !mem_ready;

      if (mul_start) begin
         mpa_d = EX_A;
         mpb_d = EX_B;
         acc_d = '0;
         cnt_d = '0;
         mpc_d = EX_PC;
         md_d  = EX_D;
         mid_d = EX_ID;
      end else if (mul_step) begin
         acc_d = acc_step;
         mpa_d = mpa_q << 1;
         mpb_d = mpb_q >> 1;
         cnt_d = cnt_q + CW'(1);
      end

      if (load_alu) begin
         mem_valid_d = 1'b1;
         mem_pc_d    = EX_PC;
         mem_y_d     = alu_y;
         mem_d_d     = EX_D;
         mem_id_d    = EX_ID;
      end else if (load_mul) begin
         // Final iteration's partial product is folded in on the completing edge.
         mem_valid_d = 1'b1;
         mem_pc_d    = mpc_q;
         mem_y_d     = acc_step;
         mem_d_d     = md_q;
         mem_id_d    = mid_q;
      end

      if (ex_flush) mem_valid_d = 1'b0;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mpa_q       <= '0;
         mpb_q       <= '0;
         acc_q       <= '0;
         mpc_q       <= '0;
         md_q        <= '0;
         mid_q       <= '0;
         mem_valid_q <= 1'b0;
         mem_pc_q    <= '0;
         mem_y_q     <= '0;
         mem_d_q     <= '0;
         mem_id_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         mpa_q       <= mpa_d;
         mpb_q       <= mpb_d;
         acc_q       <= acc_d;
         mpc_q       <= mpc_d;
         md_q        <= md_d;
         mid_q       <= mid_d;
         mem_valid_q <= mem_valid_d;
         mem_pc_q    <= mem_pc_d;
         mem_y_q     <= mem_y_d;
         mem_d_q     <= mem_d_d;
         mem_id_q    <= mem_id_d;
      end
   end

   assign mem_valid = mem_valid_q;
   assign MEM_PC    = mem_pc_q;
   assign MEM_Y     = mem_y_q;
   assign MEM_D     = mem_d_q;
   assign MEM_ID    = mem_id_q;
   assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed bench for ex_stage against a behavioural model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] EX_PC, EX_A, EX_B, EX_D, EX_ID;
   logic [5:0]  EX_ALUFN;
   logic        ex_flush;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] MEM_PC, MEM_Y, MEM_D, MEM_ID;
   logic        busy;

   always #5 clk = ~clk;

   ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .EX_PC(EX_PC), .EX_ALUFN(EX_ALUFN), .EX_A(EX_A), .EX_B(EX_B),
      .EX_D(EX_D), .EX_ID(EX_ID), .ex_flush(ex_flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .MEM_PC(MEM_PC), .MEM_Y(MEM_Y), .MEM_D(MEM_D), .MEM_ID(MEM_ID),
      .busy(busy)
   );

   localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_MUL = 6'b000010;
   localparam logic [5:0] F_SHR = 6'b100001, F_SRA = 6'b100011;
   localparam logic [5:0] F_XOR = 6'b010110, F_LT = 6'b110101, F_LE = 6'b110111;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] y;
      logic [31:0] d;
      logic [31:0] id;
   } exp_t;

   exp_t        q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference ALU from the function table, using plain arithmetic.
   function automatic logic [31:0] alu_ref(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
      int          sa, sb;
      logic [31:0] ones;
      int unsigned s;
      sa   = a;
      sb   = b;
      ones = 32'hFFFF_FFFF;
      s    = int'(b[4:0]);
      case (fn[5:4])
         2'b00: begin
            case (fn)
               6'b000000: return a + b;
               6'b000001: return a - b;
               6'b000010: return a * b;
               default:   return 32'h0;
            endcase
         end
         2'b01: return ({32{fn[0]}} & ~a & ~b) | ({32{fn[1]}} & a & ~b) |
                       ({32{fn[2]}} & ~a & b)  | ({32{fn[3]}} & a & b);
         2'b10: begin
            case (fn)
               6'b100000: return a << s;
               6'b100001: return a >> s;
               6'b100011: return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
               6'b100010: return a;
               default:   return 32'h0;
            endcase
         end
         default: begin
            case (fn)
               6'b110011: return (a == b) ? 32'd1 : 32'd0;
               6'b110101: return (sa < sb) ? 32'd1 : 32'd0;
               6'b110111: return (sa <= sb) ? 32'd1 : 32'd0;
               default:   return 32'h0;
            endcase
         end
      endcase
   endfunction

   // Output monitor: mem_valid implies the oldest undelivered op sits in the output register.
   task automatic mon();
      if (!rst_n) return;
      if (q.size() == 0) begin
         check("idle_valid", 32'(mem_valid), 32'h0);
      end else if (mem_valid) begin
         check("mem_y", MEM_Y, q[0].y);
         check("mem_pc", MEM_PC, q[0].pc);
         check("mem_d", MEM_D, q[0].d);
         check("mem_id", MEM_ID, q[0].id);
         if (mem_ready) void'(q.pop_front());
      end
      // A flush kills everything not handed to memory on that edge.
      if (ex_flush) q.delete();
   endtask

   // One clock: monitor at the falling edge, record acceptance, return just after the rising edge.
   task automatic cyc(output bit took);
      @(negedge clk);
      mon();
      took = rst_n && ex_valid && ex_ready;
      if (took) q.push_back('{EX_PC, alu_ref(EX_ALUFN, EX_A, EX_B), EX_D, EX_ID});
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      ex_valid = 1'b1;
      EX_ALUFN = fn;
      EX_A     = a;
      EX_B     = b;
      EX_PC    = $urandom;
      EX_D     = $urandom;
      EX_ID    = $urandom;
   endtask

   task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      bit took;
      took = 1'b0;
      drive_op(fn, a, b);
      for (int i = 0; i < 200 && !took; i++) cyc(took);
      check("accept_timeout", 32'(took), 32'h1);
      ex_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit took;
      ex_valid = 1'b0;
      for (int i = 0; i < n; i++) cyc(took);
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      bit took;
      issue(F_MUL, a, b);
      for (int i = 0; i < 40 && !mem_valid; i++) cyc(took);
      check("mul_done", 32'(mem_valid), 32'h1);
      check("mul_y", MEM_Y, exp);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(mem_valid), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_pc"}, MEM_PC, 32'h0);
      check({tag, "_y"}, MEM_Y, 32'h0);
      check({tag, "_d"}, MEM_D, 32'h0);
      check({tag, "_id"}, MEM_ID, 32'h0);
   endtask

   function automatic logic [5:0] pick_fn();
      int r;
      r = $urandom_range(0, 15);
      case (r)
         0:       return F_ADD;
         1:       return F_SUB;
         2:       return 6'b000011;
         3:       return ($urandom_range(0, 2) == 0) ? F_MUL : F_ADD;
         4, 5, 6: return {2'b01, 4'($urandom)};
         7, 8, 9: return {4'b1000, 2'($urandom)};
         10, 11:  return F_LT;
         12:      return F_LE;
         13:      return 6'b110011;
         default: return {2'b11, 4'($urandom)};
      endcase
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          took;
      logic [31:0] pc1, y1, va, vb;
      logic [5:0]  t_fn [5] = '{F_SRA, F_SHR, F_LT, F_LE, F_XOR};
      logic [31:0] t_a  [5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'h0000_F0F0};
      logic [31:0] t_b  [5] = '{32'd4, 32'd4, 32'd1, 32'd2, 32'h0000_FF00};
      logic [31:0] t_y  [5] = '{32'hF800_0000, 32'h0800_0000, 32'd1, 32'd1, 32'h0000_0FF0};
      int          ops;

      rst_n = 1'b0; ex_valid = 1'b0; ex_flush = 1'b0; mem_ready = 1'b1;
      EX_ALUFN = '0; EX_A = '0; EX_B = '0; EX_PC = '0; EX_D = '0; EX_ID = '0;
      #2;
      check_zero("reset");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", 32'(ex_ready), 32'h1);

      // ADD then SUB back-to-back.
      drive_op(F_ADD, 32'd5, 32'd7);
      pc1 = EX_PC;
      cyc(took);
      check("add_accept", 32'(took), 32'h1);
      drive_op(F_SUB, 32'd3, 32'd5);
      #1;
      check("add_valid", 32'(mem_valid), 32'h1);
      check("add_y", MEM_Y, 32'h0000_000C);
      check("add_pc", MEM_PC, pc1);
      cyc(took);
      check("sub_accept", 32'(took), 32'h1);
      ex_valid = 1'b0;
      check("sub_y", MEM_Y, 32'hFFFF_FFFE);
      idle(2);

      // Shift, compare and boolean vectors.
      for (int i = 0; i < 5; i++) begin
         issue(t_fn[i], t_a[i], t_b[i]);
         check("table_y", MEM_Y, t_y[i]);
      end
      idle(2);

      // MUL 7*6 latency.
      drive_op(F_MUL, 32'd7, 32'd6);
      cyc(took);
      check("mul_accept", 32'(took), 32'h1);
      ex_valid = 1'b0;
      check("mul_busy_T", 32'(busy), 32'h1);
      check("mul_ready_T", 32'(ex_ready), 32'h0);
      for (int k = 1; k < 32; k++) begin
         cyc(took);
         check("mul_busy", 32'(busy), 32'h1);
         check("mul_ready", 32'(ex_ready), 32'h0);
         check("mul_early", 32'(mem_valid), 32'h0);
      end
      cyc(took);
      check("mul_busy_end", 32'(busy), 32'h0);
      check("mul_valid_end", 32'(mem_valid), 32'h1);
      check("mul_42", MEM_Y, 32'd42);
      check("mul_ready_end", 32'(ex_ready), 32'h1);
      idle(2);
      run_mul(32'h0001_0000, 32'h0001_0000, 32'h0);
      run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      idle(2);

      // Backpressure: output held for 5 cycles, next op waits and is not lost.
      mem_ready = 1'b0;
      va = $urandom; vb = $urandom;
      issue(F_ADD, va, vb);
      y1 = va + vb;
      drive_op(F_SUB, vb, va);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready", 32'(ex_ready), 32'h0);
         check("bp_hold", MEM_Y, y1);
         check("bp_valid", 32'(mem_valid), 32'h1);
         cyc(took);
         check("bp_noaccept", 32'(took), 32'h0);
      end
      mem_ready = 1'b1;
      cyc(took);
      check("bp_accept", 32'(took), 32'h1);
      ex_valid = 1'b0;
      check("bp_next_valid", 32'(mem_valid), 32'h1);
      check("bp_next_y", MEM_Y, vb - va);
      idle(2);

      // Flush at iteration 10 of a MUL.
      issue(F_MUL, 32'd9, 32'd9);
      for (int k = 1; k < 10; k++) cyc(took);
      ex_flush = 1'b1;
      cyc(took);
      ex_flush = 1'b0;
      check("flush_busy", 32'(busy), 32'h0);
      check("flush_valid", 32'(mem_valid), 32'h0);
      drive_op(F_ADD, 32'd100, 32'd23);
      cyc(took);
      check("flush_next_accept", 32'(took), 32'h1);
      ex_valid = 1'b0;
      check("flush_next_y", MEM_Y, 32'd123);
      idle(36);

      // Flush coinciding with MUL completion discards the result.
      issue(F_MUL, 32'd11, 32'd13);
      for (int k = 1; k < 32; k++) cyc(took);
      ex_flush = 1'b1;
      cyc(took);
      ex_flush = 1'b0;
      check("flush_end_valid", 32'(mem_valid), 32'h0);
      check("flush_end_busy", 32'(busy), 32'h0);
      idle(3);

      // Reset mid-MUL, then reset while a result is held.
      issue(F_MUL, 32'd5, 32'd5);
      for (int k = 1; k < 10; k++) cyc(took);
      rst_n = 1'b0;
      #1;
      check_zero("rst_mul");
      q.delete();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_mul_ready", 32'(ex_ready), 32'h1);
      mem_ready = 1'b0;
      issue(F_ADD, 32'd1, 32'd2);
      idle(2);
      check("rst_held_valid", 32'(mem_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      check_zero("rst_held");
      q.delete();
      mem_ready = 1'b1;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_held_ready", 32'(ex_ready), 32'h1);

      // Random traffic with backpressure and occasional flushes.
      ops = 0;
      for (int c = 0; c < 20000 && ops < 500; c++) begin
         if (!ex_valid && $urandom_range(0, 9) < 7) begin
            va = pick_val();
            vb = ($urandom_range(0, 5) == 0) ? va : pick_val();
            drive_op(pick_fn(), va, vb);
         end
         mem_ready = ($urandom_range(0, 3) != 0);
         ex_flush  = ($urandom_range(0, 49) == 0);
         cyc(took);
         if (took) begin
            ex_valid = 1'b0;
            ops++;
         end
      end
      check("rand_ops", 32'(ops), 32'd500);
      ex_flush  = 1'b0;
      mem_ready = 1'b1;
      idle(40);
      check("drain", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined Beta-style processor. It consumes the operand bundle delivered by the ID/EX pipeline register (PC, ALU function, A, B, store data D, instruction ID) and evaluates the ALU function. Single-cycle operations complete in one cycle; MUL is a 32-cycle iterative operation. The result is held in a registered EX/MEM output bundle. Valid/ready handshakes sit on both sides, so the block stalls decode while a multiply runs or while memory applies backpressure.

## Interface

Parameters:
- WIDTH, 32: datapath width (PC, A, B, D, ID, Y).
- MUL_CYCLES, 32: iterations of the shift-add multiplier; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  ID/EX bundle valid.
- ex_ready  out  1  block accepts the bundle this cycle.
- EX_PC  in  32  instruction PC.
- EX_ALUFN  in  6  ALU function code.
- EX_A, EX_B  in  32  ALU operands.
- EX_D  in  32  store data, passed through.
- EX_ID  in  32  instruction word/tag, passed through.
- ex_flush  in  1  synchronous squash (branch mispredict/exception).
- mem_valid  out  1  EX/MEM bundle valid.
- mem_ready  in  1  memory stage accepts the bundle.
- MEM_PC, MEM_Y, MEM_D, MEM_ID  out  32 each  registered PC, ALU result, store data, ID.
- busy  out  1  multiplier in progress.

## Operation

- **Accept rule.** ex_ready = (state==IDLE) & (!mem_valid | mem_ready) & !ex_flush. This is combinational. A transfer occurs on a clock edge with ex_valid & ex_ready.
- **States.**
  - IDLE to IDLE on a single-cycle op: loads the output register.
  - IDLE to MUL on ALUFN=000010: latches A, B, PC, D, ID; clears the accumulator and the counter.
  - MUL to IDLE when the counter reaches MUL_CYCLES-1: loads the output register.
  - ex_flush in any state goes to IDLE.
- **Function encoding** (ALUFN[5:4] selects the class):
  - 00, arithmetic: 000000 ADD A+B; 000001 SUB A-B; 000010 MUL, the low 32 bits of A*B; 000011 Y=0. Results wrap modulo 2^32.
  - 01, boolean: Y[i] = ALUFN[{B[i],A[i]}]. AND=011000, OR=011110, XOR=010110.
  - 10, shift by B[4:0]: 100000 SHL; 100001 SHR (logical); 100011 SRA; 100010 returns Y=A.
  - 11, compare (signed), Y = 1 or 0: 110011 EQ; 110101 LT; 110111 LE; any other 11xxxx gives Y=0.
- **Multiplier.** Shift-add. Each cycle: if mcand_b[0], acc += mplier_a; then mplier_a <<= 1 and mcand_b >>= 1. Only the low 32 bits are kept.
- **Output register.** Holds its value while mem_valid & !mem_ready.
  - mem_valid clears after a handshake unless a new result loads on the same edge.
  - If the output is being consumed on the same edge a new result is produced, the new result loads.
- **Flush.** On an edge where ex_flush=1: mem_valid goes to 0, a MUL in progress is aborted, and no input is accepted. Data registers may keep stale values.
- **Pass-through fields.** D, ID and PC pass through unmodified.

## Timing

- **Reset values.** Every output is 0 during reset: mem_valid, busy, MEM_PC, MEM_Y, MEM_D, MEM_ID. The state is IDLE. ex_ready is 1 after reset while ex_flush=0.
- **Single-cycle latency.** An op accepted at edge T gives mem_valid=1 after edge T.
- **MUL latency.** A MUL accepted at edge T holds busy=1 and ex_ready=0 for edges T+1 through T+32. mem_valid=1 and the result appear after edge T+32, busy returns to 0 after edge T+32, and ex_ready may return to 1 in the cycle after edge T+32.
- **Back-to-back throughput.** With mem_ready held at 1, single-cycle ops issue at one per cycle.
- **MUL completion under backpressure.** The MUL does not finish while the output is held: it waits in its last iteration until !mem_valid | mem_ready.
- **Reset mid-MUL.** Reset asserted during a MUL aborts it immediately; outputs return to 0 asynchronously.
- **Flush with a completed result.** ex_flush asserted in the same cycle as a MUL completion discards the result.

## Test plan

- ADD 5+7, then SUB 3-5, back-to-back with mem_ready=1: MEM_Y is 0x0000000C, then 0xFFFFFFFE on consecutive cycles. MEM_PC, MEM_D and MEM_ID match the inputs.
- SRA 0x80000000 by 4 gives 0xF8000000; SHR of the same gives 0x08000000; CMPLT (-1, 1) gives 1; CMPLE (2, 2) gives 1; XOR 0xF0F0 with 0xFF00 gives 0x0FF0.
- MUL 7*6: ex_ready and busy behave as in Timing, MEM_Y=42 after edge T+32. MUL 0x00010000*0x00010000 gives 0. MUL 0xFFFFFFFF*3 gives 0xFFFFFFFD.
- Backpressure: hold mem_ready=0 for 5 cycles after an ADD. The output stays stable, ex_ready=0, a following op is not lost, and it emerges the cycle after mem_ready returns to 1.
- Flush at cycle 10 of a MUL: busy goes to 0, no mem_valid pulse occurs, and the next ADD is accepted the following cycle with a correct result.
- Assert rst_n=0 mid-MUL and while mem_valid=1: all outputs go to 0 immediately, and ex_ready=1 after release.
